// File: rtl/wshb_mire.sv
// Wishbone test-pattern master: writes an HDISP x VDISP framebuffer in raster order, in bursts of BURST.
// Optional macro WSHB_MIRE_GRADIENT_EN selects an x/y gradient instead of the default 16-pixel grid.
module wshb_mire #(
   parameter int HDISP = 800,
   parameter int VDISP = 480,
   parameter int BURST = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   output logic        wshb_cyc,
   output logic        wshb_stb,
   output logic        wshb_we,
   output logic [31:0] wshb_adr,
   output logic [31:0] wshb_dat_ms,
   output logic [3:0]  wshb_sel,
   output logic [2:0]  wshb_cti,
   output logic [1:0]  wshb_bte,
   input  logic        wshb_ack,
   input  logic        wshb_err,
   input  logic        wshb_rty,
   output logic        frame_done
);

   localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
   localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [XW-1:0] X_MAX = XW'(HDISP - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(VDISP - 1);
   localparam logic [BW-1:0] B_MAX = BW'(BURST - 1);

   typedef enum logic [1:0] {IDLE, WRITE, PAUSE} state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic            cyc_q, frame_done_q, frame_end;
   logic [31:0]     adr_q, dat_q;
   logic [31:0]     x_ext, y_ext, pix_adr, pix_dat;

   // NOTE: every variable gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      burst_d   = burst_q;
      frame_end = 1'b0;
      case (state_q)
         IDLE:  state_d = WRITE;
         WRITE: begin
            if (wshb_ack || wshb_err) begin
               // An err-terminated write is dropped: the pixel is consumed like an ack.
               if (x_q == X_MAX) begin
                  x_d = '0;
                  if (y_q == Y_MAX) begin
                     y_d       = '0;
                     frame_end = 1'b1;
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
               if (burst_q == B_MAX) begin
                  burst_d = '0;
                  state_d = PAUSE;
               end else begin
                  burst_d = burst_q + 1'b1;
               end
            end else if (wshb_rty) begin
               state_d = WRITE;
            end
         end
         PAUSE:   state_d = WRITE;
         default: state_d = IDLE;
      endcase
   end

   // Address and data are derived from the next pixel so they change only on acceptance.
   assign x_ext   = 32'(x_d);
   assign y_ext   = 32'(y_d);
   assign pix_adr = (y_ext * 32'(HDISP) + x_ext) << 2;
`ifdef WSHB_MIRE_GRADIENT_EN
   assign pix_dat = {8'h00, x_ext[7:0], y_ext[7:0], x_ext[7:0] ^ y_ext[7:0]};
`else
   assign pix_dat = ((x_ext[3:0] == 4'd0) || (y_ext[3:0] == 4'd0)) ? 32'h00FF_FFFF : 32'h0000_0000;
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         burst_q      <= '0;
         cyc_q        <= 1'b0;
         adr_q        <= '0;
         dat_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         burst_q      <= burst_d;
         cyc_q        <= (state_d == WRITE);
         adr_q        <= pix_adr;
         dat_q        <= pix_dat;
         frame_done_q <= frame_end;
      end
   end

   assign wshb_cyc    = cyc_q;
   assign wshb_stb    = cyc_q;
   assign wshb_we     = 1'b1;
   assign wshb_adr    = adr_q;
   assign wshb_dat_ms = dat_q;
   assign wshb_sel    = 4'hF;
   assign wshb_cti    = 3'b000;
   assign wshb_bte    = 2'b00;
   assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_wshb_mire.sv
// Bench for wshb_mire: a small 8x4/BURST=5 instance driven by a vector table and a pixel-index model,
// plus a default-sized instance for burst length, wait states and asynchronous reset.
module tb_wshb_mire;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        ack_s = 1'b0, err_s = 1'b0, rty_s = 1'b0;
   logic        cyc_s, stb_s, we_s, fd_s;
   logic [31:0] adr_s, dat_s;
   logic [3:0]  sel_s;
   logic [2:0]  cti_s;
   logic [1:0]  bte_s;

   logic        ack_b = 1'b0, err_b = 1'b0, rty_b = 1'b0;
   logic        cyc_b, stb_b, we_b, fd_b;
   logic [31:0] adr_b, dat_b;
   logic [3:0]  sel_b;
   logic [2:0]  cti_b;
   logic [1:0]  bte_b;

   wshb_mire #(.HDISP(8), .VDISP(4), .BURST(5)) dut_s (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .wshb_cyc(cyc_s), .wshb_stb(stb_s), .wshb_we(we_s), .wshb_adr(adr_s), .wshb_dat_ms(dat_s),
      .wshb_sel(sel_s), .wshb_cti(cti_s), .wshb_bte(bte_s),
      .wshb_ack(ack_s), .wshb_err(err_s), .wshb_rty(rty_s), .frame_done(fd_s)
   );

   wshb_mire dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .wshb_cyc(cyc_b), .wshb_stb(stb_b), .wshb_we(we_b), .wshb_adr(adr_b), .wshb_dat_ms(dat_b),
      .wshb_sel(sel_b), .wshb_cti(cti_b), .wshb_bte(bte_b),
      .wshb_ack(ack_b), .wshb_err(err_b), .wshb_rty(rty_b), .frame_done(fd_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [31:0] pix(input int x, input int y);
`ifdef WSHB_MIRE_GRADIENT_EN
      logic [7:0] xb, yb;
      xb = x[7:0];
      yb = y[7:0];
      return {8'h00, xb, yb, xb ^ yb};
`else
      return ((x % 16 == 0) || (y % 16 == 0)) ? 32'h00FF_FFFF : 32'h0000_0000;
`endif
   endfunction

   typedef struct {
      logic        ack, err, rty;
      logic        cyc;
      logic [31:0] adr, dat;
      logic        fd;
   } vec_t;

   vec_t vecs[17];

   initial begin
      int p, nb, fd_count;
      bit pause_now, fd_exp, coincide_seen;

      // Outputs are what the DUT shows before the inputs of the same row are clocked in.
      vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'h0,    1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  pix(0,0), 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd0,  pix(0,0), 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd0,  pix(0,0), 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd4,  pix(1,0), 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  pix(2,0), 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd12, pix(3,0), 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd12, pix(3,0), 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd16, pix(4,0), 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd20, pix(5,0), 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd20, pix(5,0), 1'b0};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd24, pix(6,0), 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd28, pix(7,0), 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd32, pix(0,1), 1'b0};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd36, pix(1,1), 1'b0};
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd40, pix(2,1), 1'b0};
      vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd40, pix(2,1), 1'b0};

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst cyc", 32'(cyc_s), 32'd0);
      check("rst stb", 32'(stb_s), 32'd0);
      check("rst adr", adr_s, 32'd0);
      check("rst dat", dat_s, 32'd0);
      check("rst frame_done", 32'(fd_s), 32'd0);
      check("rst we", 32'(we_s), 32'd1);
      check("rst sel", 32'(sel_s), 32'hF);
      check("rst cti", 32'(cti_s), 32'd0);
      check("rst bte", 32'(bte_s), 32'd0);
      check("rst big cyc", 32'(cyc_b), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         check($sformatf("vec%0d cyc", i), 32'(cyc_s), 32'(vecs[i].cyc));
         check($sformatf("vec%0d stb", i), 32'(stb_s), 32'(vecs[i].cyc));
         check($sformatf("vec%0d adr", i), adr_s, vecs[i].adr);
         check($sformatf("vec%0d dat", i), dat_s, vecs[i].dat);
         check($sformatf("vec%0d frame_done", i), 32'(fd_s), 32'(vecs[i].fd));
         ack_s = vecs[i].ack;
         err_s = vecs[i].err;
         rty_s = vecs[i].rty;
         step();
      end

      // Pixels 0..10 accepted so far, one pixel into the current burst; run to the end of frame 5,
      // where the 160th acceptance is both a frame wrap and a burst end.
      p = 11; nb = 1; pause_now = 1'b0; fd_exp = 1'b0; coincide_seen = 1'b0; fd_count = 0;
      ack_s = 1'b1; err_s = 1'b0; rty_s = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (pause_now) begin
            check($sformatf("run p%0d pause cyc", p), 32'(cyc_s), 32'd0);
         end else begin
            check($sformatf("run p%0d cyc", p), 32'(cyc_s), 32'd1);
            check($sformatf("run p%0d adr", p), adr_s, 32'(4 * (p % 32)));
            check($sformatf("run p%0d dat", p), dat_s, pix((p % 32) % 8, (p % 32) / 8));
            if (p == 19) begin
`ifdef WSHB_MIRE_GRADIENT_EN
               check("pixel(3,2) dat", dat_s, 32'h0003_0201);
`else
               check("pixel(3,2) dat", dat_s, 32'h0000_0000);
`endif
            end
         end
         check($sformatf("run p%0d frame_done", p), 32'(fd_s), 32'(fd_exp));
         if (fd_s === 1'b1) fd_count++;
         if (fd_exp && pause_now) coincide_seen = 1'b1;
         if (p == 160) break;
         if (pause_now) begin
            pause_now = 1'b0;
            fd_exp    = 1'b0;
         end else begin
            p++;
            nb++;
            fd_exp    = (p % 32 == 0);
            pause_now = (nb == 5);
            if (nb == 5) nb = 0;
         end
         step();
      end
      check("run reached frame 5", 32'(p), 32'd160);
      check("frame_done pulses", 32'(fd_count), 32'd5);
      check("wrap with pause", 32'(coincide_seen), 32'd1);

      // Default-sized instance: sitting in WRITE at pixel 0 with no ack; reset it asynchronously.
      check("big pre-reset cyc", 32'(cyc_b), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("async rst cyc", 32'(cyc_b), 32'd0);
      check("async rst adr", adr_b, 32'd0);
      #12 rst_n = 1'b1;
      @(negedge clk);
      check("big idle cyc", 32'(cyc_b), 32'd0);
      step();
      check("big first stb", 32'(stb_b), 32'd1);
      check("big first adr", adr_b, 32'd0);
      check("big first dat", dat_b, pix(0, 0));

      for (int k = 0; k < 64; k++) begin
         if (k == 3) begin
            ack_b = 1'b0;
            for (int h = 0; h < 5; h++) begin
               check($sformatf("wait%0d cyc", h), 32'(cyc_b), 32'd1);
               check($sformatf("wait%0d adr", h), adr_b, 32'd12);
               check($sformatf("wait%0d dat", h), dat_b, pix(3, 0));
               step();
            end
         end
         ack_b = 1'b1;
         check($sformatf("burst k%0d cyc", k), 32'(cyc_b), 32'd1);
         check($sformatf("burst k%0d adr", k), adr_b, 32'(4 * k));
         check($sformatf("burst k%0d dat", k), dat_b, pix(k, 0));
         step();
      end
      check("big pause cyc", 32'(cyc_b), 32'd0);
      check("big pause adr", adr_b, 32'd256);
      step();
      check("big resume cyc", 32'(cyc_b), 32'd1);
      check("big resume adr", adr_b, 32'd256);
      check("big resume dat", dat_b, pix(64, 0));
      ack_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wshb_mire.md
WSHB_MIRE -- requirements
Module: wshb_mire

Interface
REQ-001 The block SHALL have parameter HDISP, default 800, frame width in pixels.
REQ-002 The block SHALL have parameter VDISP, default 480, frame height in lines.
REQ-003 The block SHALL have parameter BURST, default 64, number of acknowledged writes before releasing the bus.
REQ-004 The block SHALL have port sys_clk  input  1  system clock, 100 MHz.
REQ-005 The block SHALL have port sys_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port wshb_cyc  output  1  Wishbone cycle.
REQ-007 The block SHALL have port wshb_stb  output  1  Wishbone strobe.
REQ-008 The block SHALL have port wshb_we  output  1  write enable, constant 1.
REQ-009 The block SHALL have port wshb_adr  output  32  byte address.
REQ-010 The block SHALL have port wshb_dat_ms  output  32  pixel data, {8'h00,R,G,B}.
REQ-011 The block SHALL have port wshb_sel  output  4  byte select, constant 4'hF.
REQ-012 The block SHALL have port wshb_cti  output  3  cycle type, constant 3'b000 (classic).
REQ-013 The block SHALL have port wshb_bte  output  2  burst type, constant 2'b00.
REQ-014 The block SHALL have port wshb_ack  input  1  slave acknowledge.
REQ-015 The block SHALL have port wshb_err  input  1  slave error.
REQ-016 The block SHALL have port wshb_rty  input  1  slave retry.
REQ-017 The block SHALL have port frame_done  output  1  one-cycle pulse on acceptance of the last pixel of a frame.

Function
REQ-018 The block SHALL write every pixel of the HDISP x VDISP framebuffer, raster order, at wshb_adr = 4*(y*HDISP + x), base address 0.
REQ-019 The block SHALL use counters x (0..HDISP-1) and y (0..VDISP-1), each sized $clog2 of its limit; the address product SHALL be computed at 32 bits without truncation.
REQ-020 The block SHALL implement states IDLE, WRITE and PAUSE.
REQ-021 IDLE: cyc=stb=0; unconditionally go to WRITE next cycle.
REQ-022 WRITE: cyc=stb=1; adr and dat_ms SHALL stay stable while stb=1 and no ack/err arrives.
REQ-023 A cycle with ack=1 or err=1 in WRITE SHALL accept the current pixel: x increments, wrapping to 0 with y incrementing at x=HDISP-1; adr/dat_ms update on the next edge.
REQ-024 A write terminated by err SHALL be dropped and not retried.
REQ-025 A cycle with rty=1 and ack=err=0 SHALL not advance; the same pixel SHALL be re-presented.
REQ-026 If ack and rty are both 1, ack SHALL win.
REQ-027 After BURST accepted pixels the block SHALL go to PAUSE for exactly one cycle (cyc=stb=0), then return to WRITE; the burst counter SHALL reset to 0.
REQ-028 On acceptance of pixel (HDISP-1,VDISP-1), x and y SHALL wrap to (0,0), frame_done SHALL pulse for one cycle, and writing SHALL continue indefinitely with the next frame.
REQ-029 If frame wrap and burst end coincide, both SHALL take effect: frame_done pulses and PAUSE is entered.
REQ-030 The default pattern SHALL be a grid: 32'h00FFFFFF when x%16==0 or y%16==0, otherwise 32'h00000000.

Reset
REQ-031 On sys_rst_n=0, the block SHALL immediately force state=IDLE, x=y=0, burst counter=0, cyc=stb=0, adr=0, dat_ms=0, frame_done=0; we, sel, cti, bte keep their constants.
REQ-032 Reset asserted mid-transfer SHALL drop the pending write; after release writing SHALL restart at pixel (0,0).

Configuration
REQ-033 Macro WSHB_MIRE_GRADIENT_EN: when defined, dat_ms SHALL be {8'h00, x[7:0], y[7:0], x[7:0]^y[7:0]}; when undefined, the REQ-030 grid SHALL be used. Timing and addressing SHALL be identical in both builds.

Verification
REQ-034 Release reset, ack always 1 -> first stb at cycle 2; adr 0,4,8,... with dat 32'h00FFFFFF at x=0; PAUSE after 64 acks.
REQ-035 ack held 0 for 5 cycles at pixel 3 -> adr=12 and dat_ms stable for all 5 cycles; advances on the first ack.
REQ-036 rty=1 for 2 cycles, then ack -> same address presented 3 times, one accepted; err=1 once -> pixel skipped, no retry.
REQ-037 Full frame with HDISP=8, VDISP=4, BURST=5 -> last adr=124, frame_done pulses once; next adr=0; PAUSE coincident with wrap where applicable.
REQ-038 sys_rst_n low mid-WRITE for 1 cycle, not aligned to a clock edge -> cyc=0 immediately; restart at adr=0 after release.
REQ-039 Build with WSHB_MIRE_GRADIENT_EN at pixel (3,2) -> dat_ms=32'h00030201; without it -> 32'h00000000.
